// File: rtl/tnn_pkg.sv
// Shared types and constants for the ternary neuron datapath.
package tnn_pkg;

   localparam int DEF_PC_W = 5;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

   localparam logic [1:0] ACT_POS  = 2'b01;
   localparam logic [1:0] ACT_NEG  = 2'b11;
   localparam logic [1:0] ACT_ZERO = 2'b00;

endpackage

// File: rtl/tnn_thresh_cmp.sv
// Maps a signed neuron sum to an activation code against thresholds.
// TNN_TERNARY_OUT_EN selects ternary output; otherwise binary (thr_lo absent).
module tnn_thresh_cmp
   import tnn_pkg::*;
#(
   parameter int ACC_W = 8
) (
`ifdef TNN_TERNARY_OUT_EN
   input  logic signed [ACC_W-1:0] thr_lo_i,
`endif
   input  logic signed [ACC_W-1:0] sum_i,
   input  logic signed [ACC_W-1:0] thr_hi_i,
   output logic        [1:0]       act_o
);

   logic ge_hi;

   assign ge_hi = (sum_i >= thr_hi_i);

`ifdef TNN_TERNARY_OUT_EN
   logic le_lo;

   assign le_lo = (sum_i <= thr_lo_i);

   // Upper threshold wins when the two ranges overlap
   always_comb begin
      act_o = ACT_ZERO;
      if (ge_hi) begin
         act_o = ACT_POS;
      end else if (le_lo) begin
         act_o = ACT_NEG;
      end
   end
`else
   assign act_o = ge_hi ? ACT_POS : ACT_ZERO;
`endif

endmodule

// File: rtl/tnn_popcount_accum.sv
// Accumulates pos/neg popcount deltas over NUM_CHUNKS beats, then thresholds.
// Define TNN_TERNARY_OUT_EN for ternary output; default is a binary neuron.
module tnn_popcount_accum
   import tnn_pkg::*;
#(
   parameter int NUM_CHUNKS = 4,
   parameter int PC_W       = DEF_PC_W,
   parameter int ACC_W      = $clog2(31*NUM_CHUNKS+1)+1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic        [PC_W-1:0]  pc_pos,
   input  logic        [PC_W-1:0]  pc_neg,
   input  logic signed [ACC_W-1:0] thr_hi,
   input  logic signed [ACC_W-1:0] thr_lo,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic        [1:0]       out_act,
   output logic signed [ACC_W-1:0] out_sum
);

   localparam int CNT_W = $clog2(NUM_CHUNKS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS-1);

   state_e                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] sum_q, sum_d;
   logic        [CNT_W-1:0] cnt_q, cnt_d;
   logic        [1:0]       act_q, act_d;
   logic signed [ACC_W-1:0] delta;
   logic signed [ACC_W-1:0] final_sum;
   logic        [1:0]       act_c;

   assign delta     = $signed(ACC_W'(pc_pos)) - $signed(ACC_W'(pc_neg));
   assign final_sum = acc_q + delta;

   tnn_thresh_cmp #(
      .ACC_W    (ACC_W)
   ) u_cmp (
`ifdef TNN_TERNARY_OUT_EN
      .thr_lo_i (thr_lo),
`endif
      .sum_i    (final_sum),
      .thr_hi_i (thr_hi),
      .act_o    (act_c)
   );

`ifndef TNN_TERNARY_OUT_EN
   logic unused_thr_lo;
   assign unused_thr_lo = ^thr_lo;
`endif

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_act   = act_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      act_d   = act_q;
      unique case (state_q)
         ACCUM: begin
            if (in_valid) begin
               if (cnt_q == LAST) begin
                  sum_d   = final_sum;
                  act_d   = act_c;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = HOLD;
               end else begin
                  acc_d = final_sum;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         act_q   <= ACT_ZERO;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         act_q   <= act_d;
      end
   end

endmodule

// File: tb/tb_tnn_popcount_accum.sv
// Directed + random bench for tnn_popcount_accum against an arithmetic model.
// Works for both the binary and the TNN_TERNARY_OUT_EN build.
module tb_tnn_popcount_accum;

   localparam int NC  = 4;
   localparam int PCW = 5;
   localparam int AW  = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [PCW-1:0]       pc_pos = '0;
   logic [PCW-1:0]       pc_neg = '0;
   logic signed [AW-1:0] thr_hi = '0;
   logic signed [AW-1:0] thr_lo = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [1:0]           out_act;
   logic signed [AW-1:0] out_sum;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tnn_popcount_accum #(
      .NUM_CHUNKS (NC),
      .PC_W       (PCW),
      .ACC_W      (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc_pos    (pc_pos),
      .pc_neg    (pc_neg),
      .thr_hi    (thr_hi),
      .thr_lo    (thr_lo),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_act   (out_act),
      .out_sum   (out_sum)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic logic [1:0] ref_act(input int s, input int hi,
                                          input int lo);
`ifdef TNN_TERNARY_OUT_EN
      if (s >= hi) return 2'b01;
      if (s <= lo) return 2'b11;
      return 2'b00;
`else
      if (lo > 1000) return 2'b10;
      return (s >= hi) ? 2'b01 : 2'b00;
`endif
   endfunction

   task automatic run_neuron(input string tag, input int p[NC],
                             input int n[NC], input int hi, input int lo,
                             input int gap, input int hold);
      int s;
      logic [1:0] ea;
      s = 0;
      for (int i = 0; i < NC; i++) s += p[i] - n[i];
      ea = ref_act(s, hi, lo);
      for (int i = 0; i < NC; i++) begin
         repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            pc_pos = PCW'($urandom);
            pc_neg = PCW'($urandom);
         end
         @(negedge clk);
         chk({tag, ":acc_valid"}, out_valid, 0);
         in_valid = 1'b1;
         pc_pos = PCW'(p[i]);
         pc_neg = PCW'(n[i]);
         thr_hi = (i == NC-1) ? AW'(hi) : AW'($urandom);
         thr_lo = (i == NC-1) ? AW'(lo) : AW'($urandom);
      end
      @(negedge clk);
      in_valid = 1'b0;
      thr_hi = AW'($urandom);
      thr_lo = AW'($urandom);
      chk({tag, ":out_valid"}, out_valid, 1);
      chk({tag, ":in_ready_hold"}, in_ready, 0);
      chk({tag, ":out_sum"}, out_sum, s);
      chk({tag, ":out_act"}, out_act, ea);
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1;
         pc_pos = PCW'($urandom);
         pc_neg = PCW'($urandom);
         @(negedge clk);
         chk({tag, ":hold_valid"}, out_valid, 1);
         chk({tag, ":hold_ready"}, in_ready, 0);
         chk({tag, ":hold_sum"}, out_sum, s);
         chk({tag, ":hold_act"}, out_act, ea);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, ":release_valid"}, out_valid, 0);
      chk({tag, ":release_ready"}, in_ready, 1);
   endtask

   initial begin
      int p[NC];
      int n[NC];
      int s;

      repeat (2) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_sum", out_sum, 0);
      chk("rst_act", out_act, 0);
      rst_n = 1'b1;

      p = '{31, 31, 31, 31}; n = '{0, 0, 0, 0};
      run_neuron("max_pos", p, n, 100, -100, 0, 0);
      p = '{0, 0, 0, 0}; n = '{31, 31, 31, 31};
      run_neuron("max_neg", p, n, 100, -100, 0, 0);
      p = '{10, 3, 0, 7}; n = '{5, 8, 0, 7};
      run_neuron("mixed_zero", p, n, 1, -1, 0, 0);
      p = '{20, 1, 9, 4}; n = '{3, 30, 0, 12};
      run_neuron("hold5", p, n, 5, -5, 1, 5);

      // Abort a partial sum with reset; next neuron must start from zero
      @(negedge clk);
      in_valid = 1'b1; pc_pos = 5'd5; pc_neg = 5'd0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; pc_pos = 5'd6; pc_neg = 5'd0;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_ready", in_ready, 1);
      chk("midrst_sum", out_sum, 0);
      chk("midrst_act", out_act, 0);
      @(negedge clk);
      rst_n = 1'b1;
      p = '{1, 1, 1, 1}; n = '{0, 0, 0, 0};
      run_neuron("post_rst", p, n, 100, -100, 0, 0);

      p = '{0, 0, 0, 0}; n = '{31, 31, 31, 31};
      run_neuron("bin_neg", p, n, 0, -100, 0, 0);
      p = '{31, 31, 31, 31}; n = '{0, 0, 0, 0};
      run_neuron("bin_pos", p, n, 0, -100, 0, 0);
      p = '{12, 0, 7, 2}; n = '{0, 4, 1, 6};
      run_neuron("eq_hi", p, n, 10, -10, 0, 0);
      p = '{0, 4, 1, 6}; n = '{12, 0, 7, 2};
      run_neuron("eq_lo", p, n, 10, -10, 2, 1);

      for (int k = 0; k < 20; k++) begin
         int hi;
         int lo;
         for (int i = 0; i < NC; i++) begin
            p[i] = $urandom_range(31, 0);
            n[i] = $urandom_range(31, 0);
         end
         s = 0;
         for (int i = 0; i < NC; i++) s += p[i] - n[i];
         hi = $urandom_range(60, 0) - 20;
         lo = hi - $urandom_range(60, 0);
         if (k % 4 == 0) hi = s;
         run_neuron($sformatf("rnd%0d", k), p, n, hi, lo,
                    $urandom_range(2, 0), $urandom_range(2, 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
